// File: rtl/expose_duration.sv
// expose_duration: exposure timer. It holds o_expose high for a programmed number of cycles, then flags completion.
// Optional build macro EXPOSE_ABORT_EN: when defined, dropping i_expose_enable during an exposure aborts it.
module expose_duration #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_exposecycles,
    input  logic             i_expose_enable,
    output logic             o_expose,
    output logic             o_expose_finished
);
    typedef enum logic [1:0] {IDLE, EXPOSE, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_expose;
    logic             r_finished;

    assign o_expose          = r_expose;
    assign o_expose_finished = r_finished;

    // Exposure FSM; the outputs are registered alongside the state so they always match it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_expose   <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_expose_enable) begin
                        if (i_exposecycles != '0) begin
                            r_cnt    <= i_exposecycles;
                            r_state  <= EXPOSE;
                            r_expose <= 1'b1;
                        end else begin
                            r_state    <= DONE;
                            r_finished <= 1'b1;
                        end
                    end
                end
                EXPOSE: begin
`ifdef EXPOSE_ABORT_EN
                    if (!i_expose_enable) begin
                        r_cnt    <= '0;
                        r_state  <= IDLE;
                        r_expose <= 1'b0;
                    end else
`endif
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt      <= '0;
                        r_state    <= DONE;
                        r_expose   <= 1'b0;
                        r_finished <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!i_expose_enable) begin
                        r_state    <= IDLE;
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_expose   <= 1'b0;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_expose_duration.sv
// tb_expose_duration: directed vector and corner-sequence bench for expose_duration.
module tb_expose_duration;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] n = '0;
    logic       en = 1'b0;
    logic       expose;
    logic       fin;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       en;
        logic [5:0] n;
        logic       e;
        logic       f;
    } vec_t;

    vec_t vecs[$];

    expose_duration #(.CNT_W(6)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_exposecycles    (n),
        .i_expose_enable   (en),
        .o_expose          (expose),
        .o_expose_finished (fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic ae, input logic af, input logic ee, input logic ef);
        n_cmp++;
        if ({ae, af} !== {ee, ef}) begin
            n_bad++;
            $display("FAIL %s: got expose=%b finished=%b, need expose=%b finished=%b", name, ae, af, ee, ef);
        end
    endtask

    task automatic step(input logic e, input logic [5:0] c);
        en = e;
        n  = c;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic e, input logic [5:0] c, input logic xe, input logic xf);
        vec_t v;
        v.en = e; v.n = c; v.e = xe; v.f = xf;
        vecs.push_back(v);
    endfunction

    initial begin
        int cyc;
        // N=5 with enable held
        add(1, 5, 1, 0); add(1, 5, 1, 0); add(1, 5, 1, 0); add(1, 5, 1, 0); add(1, 5, 1, 0);
        add(1, 5, 0, 1); add(1, 5, 0, 1);
        // drop one edge, then N=3
        add(0, 3, 0, 0);
        add(1, 3, 1, 0); add(1, 3, 1, 0); add(1, 3, 1, 0); add(1, 3, 0, 1);
        add(0, 3, 0, 0);
        // N=0 goes straight to DONE
        add(1, 0, 0, 1); add(1, 0, 0, 1); add(0, 0, 0, 0);
        // exposecycles changes 5->2 mid-exposure
        add(1, 5, 1, 0); add(1, 2, 1, 0); add(1, 2, 1, 0); add(1, 2, 1, 0); add(1, 2, 1, 0);
        add(1, 2, 0, 1); add(0, 2, 0, 0);
        // enable dropped mid-exposure
        add(1, 2, 1, 0);
`ifdef EXPOSE_ABORT_EN
        add(0, 2, 0, 0); add(0, 2, 0, 0); add(0, 2, 0, 0);
`else
        add(0, 2, 1, 0); add(0, 2, 0, 1); add(0, 2, 0, 0);
`endif

        #12;
        check("reset", expose, fin, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0);
        check("idle_after_reset", expose, fin, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].n);
            check($sformatf("vec%0d", i), expose, fin, vecs[i].e, vecs[i].f);
        end

        // N=63: count cycles with expose high, bounded
        step(1, 63);
        cyc = 0;
        for (int k = 0; k < 100 && expose; k++) begin
            cyc++;
            step(1, 63);
        end
        n_cmp++;
        if (cyc != 63) begin
            n_bad++;
            $display("FAIL n63_len: got %0d cycles, need 63", cyc);
        end
        check("n63_done", expose, fin, 0, 1);
        step(0, 0);
        check("n63_idle", expose, fin, 0, 0);

        // async reset mid-exposure: N=10, after 4 cycles
        step(1, 10);
        step(1, 10); step(1, 10); step(1, 10);
        check("pre_reset", expose, fin, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", expose, fin, 0, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 10);
        check("post_reset_idle", expose, fin, 0, 0);
        step(1, 1);
        check("post_reset_n1", expose, fin, 1, 0);
        step(1, 1);
        check("post_reset_n1_done", expose, fin, 0, 1);
        step(0, 1);
        check("post_reset_n1_idle", expose, fin, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
